// File: rtl/vedic_pkg.sv
// Shared constants, FSM state type and per-step shift table for the
// iterative 8x8 multiplier built around a single 4x4 Vedic core.
package vedic_pkg;

  localparam int OP_W      = 8;
  localparam int HALF_W    = 4;
  localparam int RES_W     = 16;
  localparam int NUM_STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Partial-product weight for each step: lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/vedic_seq_mul_8x8_if.sv
// Operand/result handshake bundle for vedic_seq_mul_8x8.
// master = upstream/downstream side, slave = the multiplier.
interface vedic_seq_mul_8x8_if;
  import vedic_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   multiplicand;
  logic [OP_W-1:0]   multiplier;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  result;
  logic              busy;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/VedicMul_4x4.sv
// Combinational unsigned 4x4 Vedic multiplier: four 2x2 vertical/crosswise
// blocks combined with their 2-bit weights.
module VedicMul_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] mid;
    logic [1:0] top;
    mid = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    top = {1'b0, x[1] & y[1]} + {1'b0, mid[1]};
    return {top, mid[0], x[0] & y[0]};
  endfunction

  logic [3:0] q0, q1, q2, q3;

  assign q0 = vedic_2x2(a[1:0], b[1:0]);
  assign q1 = vedic_2x2(a[3:2], b[1:0]);
  assign q2 = vedic_2x2(a[1:0], b[3:2]);
  assign q3 = vedic_2x2(a[3:2], b[3:2]);

  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};

endmodule

// File: rtl/vedic_seq_mul_8x8.sv
// Iterative unsigned 8x8 -> 16 multiplier. One VedicMul_4x4 is time-shared
// over four CALC cycles; the shifted partial products are accumulated.
// Optional macro VEDIC_SEQ_ZERO_SKIP_EN: a zero operand bypasses CALC and
// the result (0) is presented one cycle after accept.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | four accumulate steps, step 0..3
// DONE  | result held with out_valid=1 until out_ready
module vedic_seq_mul_8x8
  import vedic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  vedic_seq_mul_8x8_if.slave   bus
);

  state_t             state, state_nxt;
  logic [1:0]         step;
  logic [OP_W-1:0]    a_q, b_q;
  logic [RES_W-1:0]   acc, result_q;
  logic [HALF_W-1:0]  mul_a, mul_b;
  logic [2*HALF_W-1:0] pp;
  logic [RES_W:0]     pp_shifted;
  logic [RES_W:0]     sum;
  logic               unused_carry;
  logic               accept;

  assign accept = bus.in_valid && (state == IDLE);

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = accept && ((bus.multiplicand == '0) || (bus.multiplier == '0));
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
          state_nxt = zero_op ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (step == 2'd3) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;

  // Select the nibble pair for the current step.
  always_comb begin
    mul_a = a_q[HALF_W-1:0];
    mul_b = b_q[HALF_W-1:0];
    case (step)
      2'd1:    begin mul_a = a_q[OP_W-1:HALF_W]; mul_b = b_q[HALF_W-1:0];      end
      2'd2:    begin mul_a = a_q[HALF_W-1:0];    mul_b = b_q[OP_W-1:HALF_W];   end
      2'd3:    begin mul_a = a_q[OP_W-1:HALF_W]; mul_b = b_q[OP_W-1:HALF_W];   end
      default: ;
    endcase
  end

  VedicMul_4x4 u_mul4 (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  // Adds are 17 bits wide; the final sum is at most 65025 so bit 16 stays 0.
  assign pp_shifted   = {{(RES_W+1-2*HALF_W){1'b0}}, pp} << step_shift(step);
  assign sum          = {1'b0, acc} + pp_shifted;
  assign unused_carry = sum[RES_W];

  // Operand capture, step counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      step     <= '0;
      acc      <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q  <= bus.multiplicand;
            b_q  <= bus.multiplier;
            acc  <= '0;
            step <= '0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            if (zero_op) result_q <= '0;
`endif
          end
        end
        CALC: begin
          acc  <= sum[RES_W-1:0];
          step <= step + 2'd1;
          if (step == 2'd3) result_q <= sum[RES_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_mul_8x8.sv
// Self-checking bench for vedic_seq_mul_8x8: directed vectors with literal
// expectations plus a queue-based model checked every cycle.
module tb_vedic_seq_mul_8x8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_rdy = 1'b0;

  vedic_seq_mul_8x8_if bus();

  vedic_seq_mul_8x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // Model: expected products, accept cycle and expected latency per operand.
  int unsigned exp_q[$];
  int          acc_q[$];
  int          lat_q[$];
  bit          pending  = 1'b0;
  bit          prev_ov  = 1'b0;
  bit          hold     = 1'b0;
  logic [15:0] hold_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle monitor against the model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete(); acc_q.delete(); lat_q.delete();
      pending = 1'b0;
      prev_ov = 1'b0;
      hold    = 1'b0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(!pending));
      chk("busy", 32'(bus.busy), 32'(pending));
      if (hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_result", 32'(bus.result), 32'(hold_val));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          if (!prev_ov) chk("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
          chk("model_result", 32'(bus.result), exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front()); void'(acc_q.pop_front()); void'(lat_q.pop_front());
            pending = 1'b0;
          end
        end
      end
      hold     = bus.out_valid && !bus.out_ready;
      hold_val = bus.result;
      prev_ov  = bus.out_valid && !bus.out_ready;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(int'(bus.multiplicand) * int'(bus.multiplier));
        acc_q.push_back(cyc);
        // Out_valid seen 5 mid-cycles after the accept sample (4 CALC edges).
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        lat_q.push_back((bus.multiplicand == 0 || bus.multiplier == 0) ? 1 : 5);
`else
        lat_q.push_back(5);
`endif
        pending = 1'b1;
      end
    end
  end

  // Random downstream stalls during the regression phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #2;
    bus.in_valid     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    chk("send_timeout", 32'(ok), 32'd1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string nm);
    bit got;
    send(a, b);
    wait_valid(got);
    chk({nm, "_timeout"}, 32'(got), 32'd1);
    if (got) chk(nm, 32'(bus.result), 32'(exp));
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    nfail++;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    bit got;
    logic [7:0] ra, rb;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result),    32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);

    run_op(8'h12, 8'h34, 16'h03A8, "basic");
    run_op(8'd255, 8'd255, 16'hFE01, "max");
    run_op(8'd1, 8'd255, 16'h00FF, "one_x_max");
    run_op(8'd16, 8'd16, 16'h0100, "shift4");
    run_op(8'd0, 8'd77, 16'h0000, "zero_a");

    // Back-pressure: result held, in_ready low, extra in_valid ignored.
    bus.out_ready = 1'b0;
    send(8'd7, 8'd9);
    wait_valid(got);
    chk("bp_timeout", 32'(got), 32'd1);
    chk("bp_result", 32'(bus.result), 32'h3F);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      bus.in_valid     = (i == 1);
      bus.multiplicand = 8'd9;
      bus.multiplier   = 8'd9;
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
      chk("bp_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_hold",     32'(bus.result),    32'h3F);
    end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    @(negedge clk);
    chk("bp_idle_ready", 32'(bus.in_ready),  32'd1);
    chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_idle_result", 32'(bus.result),   32'h3F);

    // Reset asserted during step2 of 200*100.
    send(8'd200, 8'd100);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid",  32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'(bus.result),    32'd0);
    chk("midrst_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_busy",   32'(bus.busy),      32'd0);
    run_op(8'd3, 8'd5, 16'h000F, "after_rst");

    // Random regression with random stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) ra = 8'd0;
      send(ra, rb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin got = 1'b1; break; end
    end
    chk("drain", 32'(got), 32'd1);
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/vedic_seq_mul_8x8.md
Name: vedic_seq_mul_8x8

Overview:
- Iterative unsigned 8x8 -> 16-bit multiplier built around one existing VedicMul_4x4 instance.
- It is the stage directly above the 4x4 Vedic multiplier. It feeds that multiplier four 4-bit operand pairs over four cycles and accumulates the four shifted partial products.
- It gives the datapath an area-cheap wide multiply with valid/ready handshakes on input and output.

Parameters:
- None. Widths are fixed: operands 8 bits, result 16 bits, split into 4-bit halves.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair is present.
- in_ready  output  1  block accepts operands; high only in IDLE.
- multiplicand  input  8  operand A, unsigned.
- multiplier  input  8  operand B, unsigned.
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- result  output  16  A*B, unsigned; stable while out_valid=1.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst=1 at an edge, regardless of state or other inputs):
  - state=IDLE, step=0, acc=0, result=0, out_valid=0, busy=0.
  - in_ready=1 from the next cycle.
  - An operand in flight is discarded; no partial result is ever emitted.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, register A and B, clear acc, step=0, go to CALC.
  - CALC: runs exactly 4 cycles; step counter is 2 bits.
    - step0: A[3:0]*B[3:0], shift 0.
    - step1: A[7:4]*B[3:0], shift 4.
    - step2: A[3:0]*B[7:4], shift 4.
    - step3: A[7:4]*B[7:4], shift 8.
    - Each edge: acc <= acc + (pp << shift), with the 16-bit add performed at 17-bit width internally.
    - The sum never exceeds 65025, so the result is truncation-free.
    - At the step3 edge: result <= final sum, out_valid <= 1, go to DONE.
  - DONE: out_valid=1, result held. On out_valid&out_ready: out_valid <= 0, go to IDLE.
    - in_ready stays 0 in DONE, so a new operand is never accepted in the same cycle as result handoff.
- The 4x4 instance's operands come from a combinational mux on step; its product is consumed in the same cycle.
- Latency: accept at edge E0 gives out_valid=1 after edge E4, i.e. 4 cycles.
- Throughput with out_ready tied high: 1 result per 6 cycles (accept, 4 CALC, DONE).
- in_valid while busy: ignored. Upstream must hold the operands, since in_ready=0.
- out_ready while out_valid=0: no effect.
- result is only updated at the step3 edge and at reset; it keeps its last value in IDLE.

Optional Feature:
- Macro: VEDIC_SEQ_ZERO_SKIP_EN.
- Defined: in IDLE, if an accepted operand has A==0 or B==0, skip CALC entirely.
  - Next edge: result=0, out_valid=1, state=DONE.
  - Latency is 1 cycle for zero operands, 4 cycles otherwise.
- Not defined: every operand pair takes the full 4-cycle CALC path, zeros included. No extra logic is compiled.

Decomposition:
- Package vedic_pkg:
  - Constants OP_W=8, HALF_W=4, RES_W=16, NUM_STEPS=4.
  - State enum {IDLE, CALC, DONE}.
  - Per-step shift amounts {0,4,4,8}.
- Sub-module: the existing VedicMul_4x4, one instance, reused unchanged. No new sub-module.
- Top-level contents: FSM, step counter, operand mux, accumulator.

Test Plan:
- Basic product: A=8'h12, B=8'h34, out_ready=1 -> out_valid rises 4 cycles after accept with result=16'h03A8; in_ready=0 during those cycles.
- Max corner: A=255, B=255 -> result=65025 (16'hFE01), no overflow. Also A=1, B=255 -> 255, and A=16, B=16 -> 256 (exercises the shift-4 steps).
- Back-pressure: out_ready=0 for 3 cycles after out_valid -> result and out_valid held constant, in_ready=0, a new in_valid pulse is ignored. Raising out_ready -> one handoff, then IDLE with in_ready=1.
- Reset mid-operation: assert rst during step2 of A=200, B=100 -> next cycle out_valid=0, result=0, in_ready=1. A fresh A=3, B=5 then yields 15.
- Random regression: 1000 random pairs with random out_ready stalls -> every result equals A*B, delivered in accept order, none dropped or duplicated.
- Zero operand: A=0, B=77 -> result=0. Latency is 1 cycle with VEDIC_SEQ_ZERO_SKIP_EN defined, 4 cycles without it.
